// File: rtl/phy_tx_scheduler_if.sv
// phy_tx_scheduler_if: per-source word handshake bundle
// between packet sources and the PHY transmit scheduler.
interface phy_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );
endinterface

// File: rtl/phy_tx_scheduler.sv
// phy_tx_scheduler: COM preamble after reset, then round-robin
// packet arbitration with a burst cap onto the PHY word slot.
module phy_tx_scheduler #(
  parameter int          NUM_REQ     = 4,
  parameter int          SYNC_WORDS  = 4,
  parameter int          MAX_BURST   = 8,
  parameter int          WORD_CYCLES = 1,
  parameter logic [31:0] COM_WORD    = 32'hBCBCBCBC,
  parameter logic [31:0] IDLE_WORD   = 32'h7C7C7C7C
) (
  input  logic                       clk_32f,
  input  logic                       reset,
  phy_tx_scheduler_if.slave          req,
  output logic [31:0]                data_in,
  output logic                       valid_in,
  output logic                       link_up,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int IW  = $clog2(NUM_REQ);
  localparam int SLW = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1;
  localparam int SYW = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
  localparam int BW  = $clog2(MAX_BURST + 1);

  typedef enum logic {
    SYNC,
    ACTIVE
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [SLW-1:0] slot_cnt;
  logic [SYW-1:0] sync_cnt;
  logic [BW-1:0]  burst_cnt;
  logic [IW-1:0]  rr_ptr;
  logic           granted;

  logic           slot_tick;
  logic           sync_done;
  logic           found;
  logic [IW:0]    cand;
  logic [IW-1:0]  win_id;
  logic [IW-1:0]  sel_id;
  logic [IW-1:0]  nxt_ptr;
  logic           sel_ok;
  logic           sel_last;
  logic [31:0]    sel_data;
  logic           accept;
  logic           rel;

  assign slot_tick = slot_cnt == SLW'(WORD_CYCLES - 1);
  assign sync_done = slot_tick
                  && (sync_cnt == SYW'(SYNC_WORDS - 1));

  // Scan from the far end so the closest valid source to rr_ptr wins.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ))
        cand = cand - (IW+1)'(NUM_REQ);
      if (req.req_valid[cand[IW-1:0]]) begin
        found  = 1'b1;
        win_id = cand[IW-1:0];
      end
    end
  end

  assign sel_id = granted ? grant_id : win_id;
  assign sel_ok = granted ? req.req_valid[grant_id] : found;
  assign accept = reset && (state == ACTIVE)
               && slot_tick && sel_ok;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == sel_id) begin
        sel_data = req.req_data[32*i +: 32];
        sel_last = req.req_last[i];
      end
    end
  end

  always_comb begin
    req.req_ready         = '0;
    req.req_ready[sel_id] = accept;
  end

  assign rel = sel_last
            || (burst_cnt == BW'(MAX_BURST - 1));
  assign nxt_ptr = (sel_id == IW'(NUM_REQ - 1))
                 ? '0 : sel_id + 1'b1;

  always_comb begin
    state_nx = state;
    case (state)
      SYNC:    if (sync_done) state_nx = ACTIVE;
      ACTIVE:  state_nx = ACTIVE;
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) state <= SYNC;
    else        state <= state_nx;
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      slot_cnt  <= '0;
      sync_cnt  <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
      granted   <= 1'b0;
      grant_id  <= '0;
      data_in   <= '0;
      valid_in  <= 1'b0;
      link_up   <= 1'b0;
    end else begin
      slot_cnt <= slot_tick ? '0 : slot_cnt + 1'b1;
      if (slot_tick) begin
        case (state)
          SYNC: begin
            data_in  <= COM_WORD;
            valid_in <= 1'b0;
            sync_cnt <= sync_cnt + 1'b1;
            if (sync_done) link_up <= 1'b1;
          end
          ACTIVE: begin
            if (accept) begin
              data_in  <= sel_data;
              valid_in <= 1'b1;
              grant_id <= sel_id;
              if (rel) begin
                granted   <= 1'b0;
                burst_cnt <= '0;
                rr_ptr    <= nxt_ptr;
              end else begin
                granted   <= 1'b1;
                burst_cnt <= burst_cnt + 1'b1;
              end
            end else begin
              data_in  <= IDLE_WORD;
              valid_in <= 1'b0;
            end
          end
        endcase
      end
    end
  end
endmodule
